// File: rtl/serial_subtractor_4bit_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and default width.
package sub_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_4bit_fs.sv
// Behavioural single-bit full subtractor: diff = a - b - bin with borrow-out.
module full_subtractor_bh (
  output logic diff,
  output logic bout,
  input  logic a,
  input  logic b,
  input  logic bin
);

  always_comb begin
    diff = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
  end

endmodule

// File: rtl/serial_subtractor_4bit.sv
// Bit-serial subtractor: d = a - b - bin computed LSB first, one bit per clock.
module serial_subtractor_4bit
  import sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             ready,
  output logic             busy,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             done
);

  // Handshake: start is honoured only on an edge where ready=1; a/b/bin are
  // captured on that same edge. done pulses for one cycle when d/bout update.

  state_t           state;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] acc;
  logic             brw;
  logic [CNT_W-1:0] cnt;
  logic             bit_diff;
  logic             bit_borrow;

  full_subtractor_bh u_fs (
    .diff (bit_diff),
    .bout (bit_borrow),
    .a    (opa[0]),
    .b    (opb[0]),
    .bin  (brw)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ready <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
      d     <= '0;
      bout  <= 1'b0;
      opa   <= '0;
      opb   <= '0;
      acc   <= '0;
      brw   <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            opa   <= a;
            opb   <= b;
            brw   <= bin;
            cnt   <= '0;
            acc   <= '0;
            state <= RUN;
            ready <= 1'b0;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          acc <= {bit_diff, acc[WIDTH-1:1]};
          opa <= opa >> 1;
          opb <= opb >> 1;
          brw <= bit_borrow;
          cnt <= cnt + 1'b1;
          // Last bit: publish the full result directly, bypassing acc.
          if (cnt == CNT_W'(WIDTH - 1)) begin
            d     <= {bit_diff, acc[WIDTH-1:1]};
            bout  <= bit_borrow;
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
        end
        default: begin
          done  <= 1'b0;
          state <= IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor_4bit.sv
// Self-checking bench for serial_subtractor_4bit against an arithmetic reference model.
module tb_serial_subtractor_4bit;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         ready;
  logic         busy;
  logic [W-1:0] d;
  logic         bout;
  logic         done;

  int n_cmp;
  int n_err;
  logic [W:0] last_res;
  logic [W:0] exp_q[$];

  serial_subtractor_4bit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .ready (ready),
    .busy  (busy),
    .d     (d),
    .bout  (bout),
    .done  (done)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [W:0] ref_sub(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                         input logic rbin);
    int diff;
    diff = int'(ra) - int'(rb) - int'(rbin);
    // {bout, d}: borrow set when the true difference is negative
    ref_sub = {diff < 0, W'(diff < 0 ? diff + (1 << W) : diff)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 20; i++) begin
      if (ready) break;
      tick();
    end
    check("wait_ready", ready, 1);
  endtask

  // driver: one operation with full handshake, latency and hold checks
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbin);
    logic [W:0] exp;
    int  cyc;
    bit  got;
    exp_q.push_back(ref_sub(ta, tb, tbin));
    wait_ready();
    a = ta; b = tb; bin = tbin; start = 1'b1;
    tick();
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
    check("ready_drop", ready, 0);
    check("busy_rise", busy, 1);
    got = 0;
    cyc = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      cyc = i;
      if (ready === busy) check("ready_busy_excl", {ready, busy}, {~busy, busy});
      if (done) begin
        got = 1;
        break;
      end
      check("hold_d", {bout, d}, last_res);
    end
    check("done_timeout", got, 1);
    check("latency", cyc, W);
    exp = exp_q.pop_front();
    check("result", {bout, d}, exp);
    last_res = exp;
    tick();
    check("done_one_cycle", done, 0);
    check("ready_back", ready, 1);
    check("result_hold", {bout, d}, last_res);
  endtask

  initial begin
    int pulses;
    int last_pulse;
    n_cmp = 0;
    n_err = 0;
    last_res = '0;
    start = 0; a = '0; b = '0; bin = 0;
    rst_n = 0;
    #12;
    check("rst_ready", ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", {bout, d}, 0);
    rst_n = 1;
    tick();

    // directed cases
    run_op(4'd9, 4'd3, 1'b0);
    run_op(4'd3, 4'd9, 1'b0);
    run_op(4'd0, 4'd0, 1'b1);
    run_op(4'd15, 4'd15, 1'b1);
    run_op(4'd15, 4'd0, 1'b0);

    // start while busy is ignored
    wait_ready();
    a = 4'd8; b = 4'd1; bin = 0; start = 1;
    tick();
    start = 0;
    tick();
    a = 4'd2; b = 4'd2; start = 1;
    tick();
    start = 0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) break;
      tick();
    end
    check("busy_done_seen", done, 1);
    check("busy_result", {bout, d}, ref_sub(4'd8, 4'd1, 1'b0));
    start = 1;
    tick();
    start = 0;
    check("busy_done_ready", ready, 1);
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) pulses++;
    end
    check("busy_no_second", pulses, 0);
    check("busy_result_hold", {bout, d}, ref_sub(4'd8, 4'd1, 1'b0));
    last_res = ref_sub(4'd8, 4'd1, 1'b0);

    // back-to-back with start held high
    wait_ready();
    a = 4'd5; b = 4'd2; bin = 0; start = 1;
    pulses = 0;
    last_pulse = 0;
    for (int i = 1; i <= 17; i++) begin
      tick();
      if (done) begin
        if (pulses > 0) check("b2b_period", i - last_pulse, W + 2);
        else check("b2b_first", i, W + 1);
        check("b2b_result", {bout, d}, ref_sub(4'd5, 4'd2, 1'b0));
        pulses++;
        last_pulse = i;
      end else if (pulses > 0) begin
        check("b2b_hold", {bout, d}, ref_sub(4'd5, 4'd2, 1'b0));
      end
    end
    start = 0;
    check("b2b_pulses", pulses, 3);
    last_res = ref_sub(4'd5, 4'd2, 1'b0);
    tick();

    // asynchronous reset in the middle of a run
    wait_ready();
    a = 4'd9; b = 4'd3; bin = 0; start = 1;
    tick();
    start = 0;
    tick();
    tick();
    rst_n = 0;
    #1;
    check("mid_rst_result", {bout, d}, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_ready", ready, 1);
    check("mid_rst_busy", busy, 0);
    last_res = '0;
    tick();
    rst_n = 1;
    tick();
    run_op(4'd6, 4'd1, 1'b0);

    // exhaustive sweep
    for (int i = 0; i < 512; i++)
      run_op(W'(i >> 5), W'(i >> 1), 1'(i));

    // random operands
    for (int i = 0; i < 40; i++)
      run_op(W'($urandom_range(0, 15)), W'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serial_subtractor_4bit.md
Name: serial_subtractor_4bit

Overview:
- Bit-serial, multi-cycle subtractor. Computes d = a - b - bin and a borrow-out, one bit per clock, LSB first.
- It is the subtract-direction counterpart of the team's combinational ripple adder. It serves area-constrained datapaths that can tolerate WIDTH+1 cycles of latency.
- Uses a start/ready/done handshake so a sequencer can launch one operation at a time.

Parameters:
- WIDTH, 4, operand and result width in bits (legal range 2..32).
- CNT_W, $clog2(WIDTH)+1, bit-counter width (derived; not to be overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous assert, active-low.
- start  input  1  request; sampled only while ready=1.
- a  input  WIDTH  minuend; sampled at the accepting edge.
- b  input  WIDTH  subtrahend; sampled at the accepting edge.
- bin  input  1  borrow-in; sampled at the accepting edge.
- ready  output  1  high only in IDLE.
- busy  output  1  high in RUN and DONE.
- d  output  WIDTH  registered difference; holds last result.
- bout  output  1  registered borrow-out; holds last result.
- done  output  1  single-cycle pulse; d/bout are new in this cycle.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, ready=1, busy=0, done=0, d=0, bout=0, internal shift registers/counter/borrow flop = 0.
- FSM states: IDLE, RUN, DONE.
- IDLE -> RUN on an edge with start=1. At that edge:
  - opA <= a, opB <= b, brw <= bin, cnt <= 0, acc <= 0.
- RUN, each edge:
  - Bit op on opA[0], opB[0], brw: diff = opA[0] ^ opB[0] ^ brw; borrow = (~opA[0] & opB[0]) | (~(opA[0] ^ opB[0]) & brw).
  - acc <= {diff, acc[WIDTH-1:1]}; opA, opB shift right by 1; brw <= borrow; cnt <= cnt+1.
- RUN -> DONE on the edge where cnt == WIDTH-1 (the WIDTH-th RUN edge). At that same edge:
  - d <= {diff, acc[WIDTH-1:1]}; bout <= borrow.
- DONE: done=1 for exactly one cycle; unconditional -> IDLE on the next edge.
- Latency: start accepted at edge T0; done is high in the cycle after edge T0+WIDTH. Throughput is one operation per WIDTH+2 cycles.
- Arithmetic: d = (a - b - bin) mod 2^WIDTH, all operands unsigned. bout=1 iff a < b + bin, where b + bin is computed at WIDTH+1 bits. The result also equals the two's-complement difference.
- start while busy (RUN or DONE): ignored; no queuing, no error flag.
- start held high continuously: a new operation begins on the edge where IDLE is re-entered and start is sampled, i.e. the cycle after done.
- a/b/bin changes after acceptance: no effect on the running operation.
- d/bout change only on the RUN->DONE edge. Between operations they hold the last result; they never show partial results.
- Reset mid-operation: abandons the operation, no done pulse, outputs return to reset values immediately (asynchronous).
- ready and busy are mutually exclusive at all times; ready = (state==IDLE).

Decomposition:
- Shared package (sub_pkg):
  - State enumeration: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Default WIDTH constant.
- Sub-module full_subtractor_bh:
  - Ports: output diff, bout; input a, b, bin.
  - Combinational single-bit subtractor implementing the equations above.
  - Mirrors the team's behavioral full adder cell and is reusable for a future ripple subtractor.
  - Instantiated once, on the LSBs of the shift registers.
- Top level holds the FSM, counter, shift registers and output registers.

Test Plan (WIDTH=4):
- Basic no-borrow: a=9, b=3, bin=0, start for 1 cycle -> ready drops the next cycle; done high 5 cycles after the accepting edge; d=6, bout=0.
- Wrap-around / borrow: a=3, b=9, bin=0 -> d=4'hA, bout=1. Then a=0, b=0, bin=1 -> d=4'hF, bout=1.
- Extreme values: a=15, b=15, bin=1 -> d=4'hF, bout=1. Then a=15, b=0, bin=0 -> d=4'hF, bout=0.
- Busy handling: accept a=8, b=1; pulse start with a=2, b=2 during RUN and again in the DONE cycle -> exactly one done; d=7; the second request never executes.
- Back-to-back: start held high with a=5, b=2 -> done pulses every 6 cycles; d=3 each time; d stable between pulses.
- Reset mid-run: assert rst_n=0 two cycles into RUN -> d=0, bout=0, done=0, ready=1 immediately. After release, a=6, b=1 completes with d=5.
- Self-checking scoreboard: exhaustive sweep of all 512 (a, b, bin) combinations against the reference model {bout, d} = {1'b0, a} - b - bin.
